// File: rtl/uart_cmd_wrapper.sv
// UART command front end: assembles two 8N1 bytes into a 16-bit command and transmits response bytes.
// Optional build macro CMD_TIMEOUT_EN abandons a stored high byte after TIMEOUT_CYC idle cycles.
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV    = 2604,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);
  localparam int unsigned BW = $clog2(BAUD_DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // RX synchroniser plus one extra flop for falling-edge detection
  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_s;
  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], RX};
      rx_prev <= rx_sync[1];
    end
  end

  uart_state_e   rx_state, rx_state_n;
  logic [BW-1:0] rx_cnt, rx_cnt_n;
  logic [3:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          byte_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    byte_done_c = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = START;
          rx_cnt_n   = '0;
        end
      end
      START: begin
        // Mid-start-bit resample rejects short glitches
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? IDLE : DATA;
        end else begin
          rx_cnt_n = rx_cnt + BW'(1);
        end
      end
      DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_bit == 4'd7) rx_state_n = STOP;
          else                rx_bit_n   = rx_bit + 4'd1;
        end else begin
          rx_cnt_n = rx_cnt + BW'(1);
        end
      end
      STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_n  = IDLE;
          byte_done_c = rx_s;
        end else begin
          rx_cnt_n = rx_cnt + BW'(1);
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  logic byte_cnt;
  logic to_expired_c;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      to_cnt <= '0;
    else if (!byte_cnt || byte_done_c) to_cnt <= '0;
    else                             to_cnt <= to_cnt + TW'(1);
  end

  assign to_expired_c = byte_cnt && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign to_expired_c = 1'b0;
`endif

  // Command assembly; bytes arriving while a command is pending are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      byte_cnt <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (byte_done_c && !cmd_rdy) begin
        if (!byte_cnt) begin
          cmd[15:8] <= rx_shift;
          byte_cnt  <= 1'b1;
        end else begin
          cmd[7:0]  <= rx_shift;
          byte_cnt  <= 1'b0;
          cmd_rdy   <= 1'b1;
        end
      end else if (to_expired_c) begin
        byte_cnt <= 1'b0;
      end
    end
  end

  uart_state_e   tx_state, tx_state_n;
  logic [BW-1:0] tx_cnt, tx_cnt_n;
  logic [3:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_n, tx_busy_n, resp_sent_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      TX        <= 1'b1;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_bit    <= tx_bit_n;
      tx_shift  <= tx_shift_n;
      TX        <= tx_n;
      tx_busy   <= tx_busy_n;
      resp_sent <= resp_sent_n;
    end
  end

  // TX line value is computed one cycle ahead so every bit spans exactly BAUD_DIV cycles
  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_bit_n    = tx_bit;
    tx_shift_n  = tx_shift;
    tx_n        = TX;
    tx_busy_n   = tx_busy;
    resp_sent_n = 1'b0;
    case (tx_state)
      IDLE: begin
        if (send_resp) begin
          tx_state_n = START;
          tx_cnt_n   = '0;
          tx_shift_n = resp;
          tx_n       = 1'b0;
          tx_busy_n  = 1'b1;
        end
      end
      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_n       = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + BW'(1);
        end
      end
      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 4'd7) begin
            tx_state_n = STOP;
            tx_n       = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 4'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_n       = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + BW'(1);
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n  = IDLE;
          tx_busy_n   = 1'b0;
          resp_sent_n = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + BW'(1);
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: a byte-level command model and a TX frame decoder.
module tb_uart_cmd_wrapper;
  localparam int unsigned BD = 16;
  localparam int unsigned TO = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  uart_cmd_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_resp_q[$];
  int          sent_t_q[$];

  // Reference model of the command path at byte granularity
  logic        m_have = 1'b0;
  logic        m_rdy  = 1'b0;
  logic [7:0]  m_hi   = 8'h00;
  logic [15:0] m_cmd  = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_rdy) return;
    if (!m_have) begin
      m_hi = b;
      m_have = 1'b1;
    end else begin
      m_cmd = {m_hi, b};
      m_have = 1'b0;
      m_rdy = 1'b1;
      exp_cmd_q.push_back(m_cmd);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic good);
    if (good) model_byte(b);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = good;
    tick(BD);
    RX = 1'b1;
    tick(BD);
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 2000 && !cmd_rdy; i++) tick(1);
    check("cmd_rdy_rise", 32'(cmd_rdy), 32'(m_rdy));
  endtask

  task automatic clear_cmd();
    wait_rdy();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    check("cmd_rdy_cleared", 32'(cmd_rdy), 32'(m_rdy));
    check("cmd_held", 32'(cmd), 32'(m_cmd));
  endtask

  task automatic send_tx(input logic [7:0] b, input logic expect_frame);
    if (expect_frame) exp_resp_q.push_back(b);
    resp = b;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 400 && tx_busy; i++) tick(1);
    check("tx_idle", 32'(tx_busy), 32'(0));
  endtask

  task automatic wait_sent();
    for (int i = 0; i < 400 && !resp_sent; i++) tick(1);
    check("resp_sent_seen", 32'(resp_sent), 32'(1));
  endtask

  // Command monitor: every new cmd_rdy must match the oldest expected command
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && cmd_rdy && !rdy_prev) begin
      check("cmd_expected", 32'(exp_cmd_q.size() > 0), 32'(1));
      if (exp_cmd_q.size() > 0) check("cmd_value", 32'(cmd), 32'(exp_cmd_q.pop_front()));
    end
    rdy_prev = cmd_rdy;
  end

  // resp_sent pulse width and timestamps
  int sent_len = 0;
  always @(negedge clk) begin
    if (resp_sent) begin
      if (sent_len == 0) sent_t_q.push_back(cyc);
      sent_len++;
    end else if (sent_len != 0) begin
      check("resp_sent_width", 32'(sent_len), 32'(1));
      sent_len = 0;
    end
  end

  // TX decoder: mid-bit sampling from the first low cycle; frames cut by reset are dropped
  initial begin : tx_mon
    logic       tx_prev;
    logic [9:0] frame;
    logic [7:0] e;
    bit         aborted;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev && !TX) begin
        frame = '0;
        aborted = 1'b0;
        for (int k = 1; k <= 10 * BD; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (k % BD == BD / 2) frame[k / BD] = TX;
        end
        if (!aborted) begin
          check("resp_sent_at_160", 32'(resp_sent), 32'(1));
          check("tx_expected", 32'(exp_resp_q.size() > 0), 32'(1));
          if (exp_resp_q.size() > 0) begin
            e = exp_resp_q.pop_front();
            check("tx_frame", 32'(frame), 32'({1'b1, e, 1'b0}));
          end
        end
      end
      tx_prev = TX;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not finish, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] b0, b1;
    tick(3);
    check("rst_tx", 32'(TX), 32'(1));
    check("rst_cmd", 32'(cmd), 32'(0));
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'(0));
    check("rst_resp_sent", 32'(resp_sent), 32'(0));
    check("rst_tx_busy", 32'(tx_busy), 32'(0));
    rst_n = 1'b1;
    tick(2);

    // Basic command, then bytes dropped while a command is pending
    send_rx(8'h45, 1'b1);
    send_rx(8'h5A, 1'b1);
    clear_cmd();
    send_rx(8'hA1, 1'b1);
    send_rx(8'hB2, 1'b1);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    check("cmd_stable_while_rdy", 32'(cmd), 32'(m_cmd));
    clear_cmd();
    send_rx(8'h80, 1'b1);
    send_rx(8'h01, 1'b1);
    clear_cmd();

    // Framing error and start-bit glitch
    send_rx(8'h77, 1'b0);
    send_rx(8'h12, 1'b1);
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    tick(200);
    check("glitch_no_cmd", 32'(cmd_rdy), 32'(m_rdy));
    send_rx(8'h34, 1'b1);
    clear_cmd();

    // Single response with an ignored mid-frame request
    send_tx(8'hA5, 1'b1);
    check("tx_busy_set", 32'(tx_busy), 32'(1));
    tick(40);
    send_tx(8'h3C, 1'b0);
    wait_tx_idle();
    tick(5);

    // Three chained responses
    sent_t_q.delete();
    send_tx(8'h5E, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_sent();
      send_tx(8'($urandom), 1'b1);
    end
    wait_sent();
    tick(5);
    check("chain_pulses", 32'(sent_t_q.size()), 32'(3));
    if (sent_t_q.size() == 3) begin
      check("chain_spacing_1", 32'(sent_t_q[1] - sent_t_q[0]), 32'(161));
      check("chain_spacing_2", 32'(sent_t_q[2] - sent_t_q[1]), 32'(161));
    end

    // Randomized traffic on both directions at once
    fork
      begin
        for (int n = 0; n < 5; n++) begin
          if ($urandom_range(0, 3) == 0) send_rx(8'($urandom), 1'b0);
          b0 = 8'($urandom);
          b1 = 8'($urandom);
          send_rx(b0, 1'b1);
          tick($urandom_range(0, 40));
          send_rx(b1, 1'b1);
          clear_cmd();
        end
      end
      begin
        for (int n = 0; n < 5; n++) begin
          send_tx(8'($urandom), 1'b1);
          tick($urandom_range(5, 150));
          if (tx_busy) send_tx(8'($urandom), 1'b0);
          wait_tx_idle();
          tick($urandom_range(0, 30));
        end
      end
    join

    // Reset mid-frame on both directions
    send_rx(8'hDE, 1'b1);
    send_rx(8'hAD, 1'b1);
    wait_rdy();
    send_tx(8'h55, 1'b0);
    RX = 1'b0;
    tick(50);
    #2;
    rst_n = 1'b0;
    #1;
    m_have = 1'b0;
    m_rdy = 1'b0;
    m_cmd = 16'h0000;
    check("rst_mid_tx", 32'(TX), 32'(1));
    check("rst_mid_tx_busy", 32'(tx_busy), 32'(0));
    check("rst_mid_cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
    check("rst_mid_cmd", 32'(cmd), 32'(m_cmd));
    RX = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    send_rx(8'h9A, 1'b1);
    send_rx(8'hBC, 1'b1);
    clear_cmd();

`ifdef CMD_TIMEOUT_EN
    // A high byte left alone longer than the timeout is forgotten
    send_rx(8'h01, 1'b1);
    tick(600);
    m_have = 1'b0;
    send_rx(8'h02, 1'b1);
    send_rx(8'h03, 1'b1);
    clear_cmd();
`endif

    tick(20);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'(0));
    check("resp_queue_drained", 32'(exp_resp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
Serial front end of the logic analyzer command path, directly upstream of the command/config block.
- Receives 8N1 UART bytes on RX and assembles two consecutive bytes (high first) into a 16-bit command.
- Presents the command with a cmd_rdy / clr_cmd_rdy handshake.
- Transmits single response bytes requested via send_resp and pulses resp_sent when each finishes, so dump streams can pace themselves.

Parameters:
BAUD_DIV, 2604, clock cycles per UART bit (50 MHz / 19200); must be >= 4.
TIMEOUT_CYC, 1000000, cycles allowed between high and low command byte (used only with the optional feature).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  asynchronous serial input, idle high
TX  output  1  serial output, idle high
cmd  output  16  assembled command, {first byte, second byte}
cmd_rdy  output  1  cmd valid; held until cleared
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
resp  input  8  response byte to transmit
send_resp  input  1  single-cycle request to transmit resp
resp_sent  output  1  single-cycle pulse when a response frame completes
tx_busy  output  1  transmitter is mid-frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, tx_busy=0, RX sync flops=1, byte counter=0, all FSMs in IDLE. Reset mid-frame aborts both RX and TX immediately; TX returns high.
- RX synchronisation: RX passes through two flops preset to 1 before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronised falling edge.
  - START: wait BAUD_DIV/2 (integer division) and resample. If low -> DATA; if high -> IDLE (glitch rejected).
  - DATA: sample every BAUD_DIV cycles, 8 bits, LSB first.
  - STOP: sample after a further BAUD_DIV. If 1, emit an internal one-cycle byte_done. If 0 (framing error), discard the byte and leave the byte counter unchanged. Either way -> IDLE.
- Command assembly (byte counter 0/1):
  - byte_done with counter 0: cmd[15:8] <= byte, counter <= 1.
  - byte_done with counter 1: cmd[7:0] <= byte, counter <= 0, cmd_rdy <= 1 on the same edge.
  - While cmd_rdy=1, every byte_done is discarded. cmd stays stable and the counter stays 0.
  - clr_cmd_rdy=1: cmd_rdy <= 0 on the next edge. cmd keeps its value.
  - clr_cmd_rdy coincident with byte_done: clear takes effect and the byte is still discarded.
- TX FSM states: IDLE, START, DATA, STOP; each bit lasts exactly BAUD_DIV cycles.
  - send_resp in IDLE: latch resp, tx_busy <= 1, TX low starting the next cycle.
  - Frame: 0, 8 data bits LSB first, 1.
  - At the last cycle of the stop bit: -> IDLE, tx_busy <= 0, and resp_sent=1 for exactly that one following cycle.
  - send_resp while tx_busy=1 is ignored; no queueing.
  - send_resp in the same cycle resp_sent is high is accepted, giving back-to-back frames with no idle gap beyond one cycle.
- Width rules: baud counters are $clog2(BAUD_DIV)+1 bits; bit counters are 4 bits. No wrap beyond the 8 data bits.

Optional Feature:
Macro CMD_TIMEOUT_EN.
- Defined: a counter starts when the high byte is stored (counter=1). If TIMEOUT_CYC cycles pass with no second byte, the counter resets to 0 and the stored high byte is abandoned; cmd_rdy is not asserted. A later byte is therefore treated as a new high byte.
- Not defined: no timer, and the block waits indefinitely for the second byte.

Test Plan:
- Reset, then send 0x45 and 0x5A on RX (BAUD_DIV=16) -> cmd=16'h455A and cmd_rdy=1 within 1 cycle of the second stop-bit sample. Pulse clr_cmd_rdy -> cmd_rdy=0 next edge, cmd still 16'h455A.
- With cmd_rdy=1, send bytes 0x11 and 0x22 -> cmd unchanged. After clr_cmd_rdy, send 0x80 and 0x01 -> cmd=16'h8001.
- Send a byte with stop bit 0, then 0x12 and 0x34 -> the corrupted byte is dropped and cmd=16'h1234. A 3-cycle low glitch on RX produces no byte.
- send_resp with resp=8'hA5 -> TX shows 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit, then resp_sent high for exactly 1 cycle 160 cycles after TX first goes low. A second send_resp mid-frame is ignored.
- 3 chained responses (send_resp issued the cycle resp_sent pulses) -> 3 contiguous frames, 3 resp_sent pulses spaced 161 cycles apart.
- Assert rst_n low mid-TX and mid-RX -> TX=1, tx_busy=0, cmd_rdy=0 immediately. With CMD_TIMEOUT_EN and TIMEOUT_CYC=500: send 0x01, wait 600 cycles, send 0x02 and 0x03 -> cmd=16'h0203.
